// File: rtl/add_accumulator.sv
// add_accumulator: sums LEN operand beats (with per-beat carry-in) into an
// N-bit accumulator and presents the frame result with a sticky overflow flag.
// Optional build macro: ADD_ACCUMULATOR_SATURATE_EN -- a beat that carries out
// loads all ones into the accumulator instead of the wrapped sum.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where both
// valid and ready are 1. The input side is ready whenever no result is pending;
// the result is held (acc, ovf stable) until out_valid && out_ready.
// in_ready depends only on registered state, never combinationally on out_ready.

// Ripple-carry adder used as the accumulator datapath.
module adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = c[N];

endmodule

module add_accumulator #(
  parameter int N   = 4,
  parameter int LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] acc,
  output logic         ovf
);

  // Counter wide enough to hold LEN itself; it never counts past LEN.
  localparam int CW = $clog2(LEN + 1);

  // IDLE: empty frame; ACC: part of a frame absorbed; DONE: result pending.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // state is the FSM debug view; bind checkers to it hierarchically.
  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  acc_nxt;
  logic          ovf_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic [N-1:0]  sum;
  logic          cout;
  logic [N-1:0]  acc_load;
  logic          beat;
  logic          last_beat;

  adder #(.N(N)) u_adder (
    .a    (acc),
    .b    (in_data),
    .cin  (in_cin),
    .s    (sum),
    .cout (cout)
  );

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign beat      = in_valid && in_ready;
  assign last_beat = ((cnt + CW'(1)) == CW'(LEN));

`ifdef ADD_ACCUMULATOR_SATURATE_EN
  // Clamp to all ones on a carry-out; later beats keep adding from there.
  assign acc_load = cout ? {N{1'b1}} : sum;
`else
  // Plain modulo-2^N accumulation.
  assign acc_load = sum;
`endif

  // State and datapath registers; reset empties the frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode: clear wins over any beat or result handshake.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (beat) begin
            acc_nxt   = acc_load;
            ovf_nxt   = ovf | cout;
            cnt_nxt   = cnt + CW'(1);
            state_nxt = last_beat ? DONE : ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_accumulator.sv
// tb_add_accumulator: vector table, hand-written corner sequences and random
// traffic for add_accumulator (N=4, LEN=4), checked against a frame-level model.
module tb_add_accumulator;

  localparam int N   = 4;
  localparam int LEN = 4;
`ifdef ADD_ACCUMULATOR_SATURATE_EN
  localparam int SATV = 15;
`else
  localparam int SATV = 0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] acc;
  logic         ovf;

  always #5 clk = ~clk;

  add_accumulator #(.N(N), .LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .ovf       (ovf)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  logic [N:0] exp_q[$];   // {ovf, acc} of each completed frame
  int m_beats[$];         // operand+carry values accepted in the current frame

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Replays the accepted beats with integer arithmetic.
  function automatic void model_expect(output int ea, output int eo);
    int a = 0;
    eo = 0;
    foreach (m_beats[i]) begin
      a += m_beats[i];
      if (a > (1 << N) - 1) begin
        eo = 1;
`ifdef ADD_ACCUMULATOR_SATURATE_EN
        a = (1 << N) - 1;
`else
        a -= (1 << N);
`endif
      end
    end
    ea = a;
  endfunction

  task automatic check_outputs(input string tag);
    int ea, eo;
    bit done;
    model_expect(ea, eo);
    done = (m_beats.size() == LEN);
    chk({tag, " acc"}, acc, ea);
    chk({tag, " ovf"}, ovf, eo);
    chk({tag, " out_valid"}, out_valid, done);
    chk({tag, " in_ready"}, in_ready, !done);
  endtask

  // ---------------- driver ----------------
  // Called #1 after an edge: drives one cycle, updates the model, checks.
  task automatic cycle(input bit iv, input int d, input bit c, input bit ordy, input bit clr);
    bit done;
    int ea, eo;
    in_valid  = iv;
    in_data   = d[N-1:0];
    in_cin    = c;
    out_ready = ordy;
    clear     = clr;
    done = (m_beats.size() == LEN);
    if (clr) begin
      if (done && exp_q.size() > 0) void'(exp_q.pop_front());
      m_beats.delete();
    end else if (done) begin
      if (ordy) begin
        if (exp_q.size() == 0) begin
          chk("result_queue_empty", 1, 0);
        end else begin
          chk("result", {ovf, acc}, exp_q.pop_front());
        end
        m_beats.delete();
      end
    end else if (iv) begin
      m_beats.push_back(d + int'(c));
      if (m_beats.size() == LEN) begin
        model_expect(ea, eo);
        exp_q.push_back({eo[0], ea[N-1:0]});
      end
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit iv;
    int d;
    bit c;
    bit ordy;
    bit clr;
    int eacc;
    int eovf;
    int eov;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;

    // Basic frame 2,3,1+1,0 -> 2,5,7,7 then result.
    vecs.push_back('{1, 2, 0, 0, 0, 2, 0, 0});
    vecs.push_back('{1, 3, 0, 0, 0, 5, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 0, 7, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 7, 0, 1});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
    // Carry-out frame: 8 then 7+1 overflows.
    vecs.push_back('{1, 8, 0, 0, 0, 8, 0, 0});
    vecs.push_back('{1, 7, 1, 0, 0, SATV, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, SATV, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, SATV, 1, 1});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 0});

    // Reset state, held asynchronously before any clock edge.
    #2;
    chk("reset acc", acc, 0);
    chk("reset ovf", ovf, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].clr);
      chk($sformatf("vec%0d acc", i), acc, vecs[i].eacc);
      chk($sformatf("vec%0d ovf", i), ovf, vecs[i].eovf);
      chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].eov);
    end

    // Result stalled for 3 cycles while in_valid stays high.
    for (int i = 0; i < 4; i++) cycle(1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 5, 0, 0, 0);
      chk("stall acc", acc, 12);
      chk("stall out_valid", out_valid, 1);
      chk("stall in_ready", in_ready, 0);
    end
    cycle(0, 0, 0, 1, 0);
    chk("stall release acc", acc, 0);
    chk("stall release out_valid", out_valid, 0);

    // Clear together with a beat after 2 beats, then a fresh frame of ones.
    cycle(1, 5, 0, 0, 0);
    cycle(1, 6, 0, 0, 0);
    cycle(1, 9, 0, 0, 1);
    chk("clear acc", acc, 0);
    chk("clear ovf", ovf, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
    chk("after clear result", acc, 4);
    chk("after clear out_valid", out_valid, 1);
    cycle(0, 0, 0, 1, 0);

    // Reset pulsed between edges after 3 beats (ovf already set).
    cycle(1, 9, 0, 0, 0);
    cycle(1, 9, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    chk("pre-rst ovf", ovf, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst acc", acc, 0);
    chk("async rst ovf", ovf, 0);
    chk("async rst out_valid", out_valid, 0);
    chk("async rst in_ready", in_ready, 1);
    rst = 1'b0;
    m_beats.delete();
    for (int i = 0; i < 4; i++) cycle(1, 2, 0, 0, 0);
    chk("post-rst result", acc, 8);
    cycle(0, 0, 0, 1, 0);

    // Toggling in_valid: only offered beats count.
    for (int i = 0; i < 7; i++) begin
      cycle((i % 2) == 0, 1, 0, 0, 0);
      chk("toggle out_valid", out_valid, i == 6);
    end
    chk("toggle result", acc, 4);
    cycle(0, 0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand and accumulator width in bits (N >= 1).
REQ-002 SHALL have parameter LEN, default 4, giving the number of operand beats per frame (LEN >= 1).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand beat is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, N bits: the operand added to the accumulator.
REQ-009 SHALL have port in_cin, input, 1 bit: carry-in for this beat.
REQ-010 SHALL have port out_valid, output, 1 bit: the frame result is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port acc, output, N bits: the accumulator value.
REQ-013 SHALL have port ovf, output, 1 bit: sticky carry-out of the current frame.

Function
REQ-014 SHALL instantiate the existing ripple-carry module adder #(.N(N)) with a=acc, b=in_data, cin=in_cin, taking its s and cout outputs.
REQ-015 SHALL implement an FSM with states IDLE, ACC and DONE; IDLE means acc=0, ovf=0 and beat count=0.
REQ-016 SHALL drive in_ready=1 in IDLE and ACC and in_ready=0 in DONE, as a registered-state decode with no combinational path from out_ready.
REQ-017 SHALL, on a beat (in_valid && in_ready), load acc <= s, set ovf <= ovf | cout, and increment the beat count.
REQ-018 SHALL move IDLE->ACC on the first beat, and move IDLE/ACC->DONE on the beat that makes the count equal LEN; with LEN=1, the first beat goes IDLE->DONE.
REQ-019 SHALL assert out_valid only in DONE, starting the cycle after the final beat (latency 1 clock); acc and ovf SHALL hold stable while out_valid=1.
REQ-020 SHALL, in DONE with out_ready=1, return to IDLE on the next edge and clear acc, ovf and the count; out_ready SHALL be ignored outside DONE.
REQ-021 SHALL discard in_valid while in DONE: no accept and no state change.
REQ-022 SHALL let clear=1, in any state, force IDLE on the next edge; clear SHALL take priority over a simultaneous beat or out handshake, and the beat is dropped.
REQ-023 SHALL, without saturation, let the accumulator wrap modulo 2^N.
REQ-024 SHALL keep the beat counter at $clog2(LEN+1) bits with no wrap-around past LEN.

Reset
REQ-025 SHALL, while rst=1, immediately force state=IDLE, acc=0, ovf=0, count=0, out_valid=0 and in_ready=1, asynchronously.
REQ-026 SHALL abandon any partial frame when reset is asserted mid-frame, and SHALL accept a new beat on the first clk edge after rst deasserts.

Configuration
REQ-027 SHALL, when ADD_ACCUMULATOR_SATURATE_EN is defined, load acc <= all ones instead of s on a beat with cout=1; the acc value SHALL then update normally on later beats and ovf SHALL still be set.
REQ-028 SHALL, when ADD_ACCUMULATOR_SATURATE_EN is undefined, always load acc <= s, which wraps.

Verification (N=4, LEN=4)
REQ-029 SHALL cover: beats (2,0),(3,0),(1,1),(0,0) back-to-back, given as (data,cin) -> acc 2,5,7,7; out_valid=1 one cycle after the 4th beat with acc=7, ovf=0.
REQ-030 SHALL cover: beats (8,0),(7,1),(0,0),(0,0) -> without the macro, acc=0, ovf=1; with the macro, acc=15 after beat 2, then 15 at result, ovf=1.
REQ-031 SHALL cover: out_ready held low 3 cycles at result with in_valid=1 -> out_valid, acc and ovf stable, in_ready=0, no beat absorbed; out_ready=1 -> IDLE next cycle with acc=0.
REQ-032 SHALL cover: clear=1 together with in_valid=1 after 2 beats -> next cycle IDLE, acc=0, ovf=0; a following 4-beat frame of (1,0) gives result 4.
REQ-033 SHALL cover: rst pulsed between clock edges after 3 beats -> acc, ovf and out_valid drop to 0 without waiting for an edge; the next frame is correct.
REQ-034 SHALL cover: in_valid toggling 1,0,1,0 -> only cycles with in_valid=1 count; result appears after exactly 4 accepted beats.
